uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Transmit-only 8N1 UART serializer. A one-cycle data-valid strobe accepts a byte. The block then drives one start bit, eight data bits (LSB first) and one stop bit on a single serial line, each bit held for a fixed number of clocks. It sits between byte-producing control logic, such as a status/debug message streamer, and a board GPIO pin, and reports busy and done so the producer can pace bytes back-to-back.

## Interface
- CLKS_PER_BIT, default 416 (48 MHz / 115200): clock cycles per serial bit; must be >= 2.
- i_Clock  input  1  system clock; all state updates on rising edge.
- i_Rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- i_TX_DV  input  1  byte-valid strobe; sampled on rising edge; honoured only when idle.
- i_TX_Byte  input  8  byte to send; sampled on the edge that accepts i_TX_DV.
- o_TX_Active  output  1  high while a frame is in progress (busy).
- o_TX_Serial  output  1  serial line; idle/mark = 1.
- o_TX_Done  output  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP.
- Counters:
  - clock counter, width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1;
  - 3-bit bit index.
- Reset (asserted at any time, including mid-frame):
  - state IDLE, counters 0, byte register 0;
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, all immediately;
  - a frame in progress is abandoned, not resumed.
- IDLE:
  - o_TX_Serial=1, o_TX_Active=0.
  - If i_TX_DV=1 at an edge: latch i_TX_Byte, set o_TX_Active=1, drive o_TX_Serial=0, clear counter, go START.
- START: hold 0 for CLKS_PER_BIT cycles, then drive bit[0] and go DATA with index 0.
- DATA:
  - Hold bit[index] for CLKS_PER_BIT cycles.
  - Then, if index<7: increment and drive the next bit.
  - Else: drive 1 and go STOP.
- STOP: hold 1 for CLKS_PER_BIT cycles, then go IDLE with o_TX_Active=0 and o_TX_Done=1.
- o_TX_Done:
  - high for exactly one cycle, the first IDLE cycle;
  - cleared on the next edge;
  - cleared even if a new i_TX_DV is accepted on that same edge.
- Busy-time strobes: i_TX_DV while o_TX_Active=1 is ignored; that byte is lost, and no queueing occurs.
- Input stability: changes to i_TX_Byte after acceptance do not affect the frame in progress (latched copy used).

## Timing
- Let E0 be the edge that accepts i_TX_DV.
- The start bit begins on E0 (zero added latency). o_TX_Active is high at E0, so a producer that pulses DV for one cycle sees busy the following cycle.
- Data bit n (n=0..7) spans edges E0+(n+1)·CLKS_PER_BIT to E0+(n+2)·CLKS_PER_BIT.
- The stop bit spans E0+9·CLKS_PER_BIT to E0+10·CLKS_PER_BIT.
- At E0+10·CLKS_PER_BIT:
  - o_TX_Active 1->0, o_TX_Done 0->1;
  - the line stays 1.
- A new byte may be accepted at E0+10·CLKS_PER_BIT+1 (the done cycle) or later.
  - Maximum throughput is one frame per 10·CLKS_PER_BIT+1 cycles.
  - There is no glitch on o_TX_Serial between frames (at least one extra idle-high cycle).
- Every bit is exactly CLKS_PER_BIT cycles; no fractional-bit accumulation.

## Test plan
- Reset value:
  - stimulus: assert i_Rst_n=0 asynchronously (not aligned to a clock edge);
  - required: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0 immediately; line stays 1 while i_TX_DV=0.
- Single byte, CLKS_PER_BIT=4:
  - stimulus: send 0xA5;
  - required line sequence (4 cycles each): 0, 1,0,1,0,0,1,0,1, 1;
  - o_TX_Active high for exactly 40 cycles from the accepting edge;
  - o_TX_Done high for exactly 1 cycle after that.
- Default CLKS_PER_BIT=416:
  - stimulus: send 0x0C;
  - required: start bit low for exactly 416 cycles, each data bit 416 cycles, total active 4160 cycles.
- Back-to-back:
  - stimulus: producer pulses i_TX_DV one cycle whenever o_TX_Active=0, sending "HI";
  - required: decoded bytes 0x48 then 0x49, no byte dropped, at least 1 idle-high cycle between the frames.
- Busy strobe and byte change:
  - stimulus: send 0x00; mid-frame, pulse i_TX_DV with 0xFF and change i_TX_Byte;
  - required: 0x00 is transmitted unchanged, 0xFF is never sent, only one o_TX_Done pulse.
- Mid-frame reset:
  - stimulus: assert reset during data bit 3 of 0x55, then release and send 0x3C;
  - required: line returns to 1 immediately, no o_TX_Done for the aborted frame, 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_tx_core.sv
// Transmit-only 8N1 UART serializer: start bit, eight data bits LSB first, stop bit.
// Every bit lasts CLKS_PER_BIT clocks; o_TX_Done pulses on the first idle cycle after a frame.
module uart_tx_core #(
  parameter int unsigned CLKS_PER_BIT = 416
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            serial_q, serial_d;
  logic            active_q, active_d;
  logic            done_q, done_d;

  logic            bit_end;
  logic [2:0]      idx_inc;
  logic [CntW-1:0] cnt_inc;

  assign bit_end = (cnt_q == CntMax);
  assign idx_inc = idx_q + 3'd1;
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;  // done is a single-cycle pulse, even if a new byte is accepted now

    case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (i_TX_DV) begin
          byte_d   = i_TX_Byte;
          active_d = 1'b1;
          serial_d = 1'b0;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = StStart;
        end
      end

      StStart: begin
        if (bit_end) begin
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = byte_q[0];
          state_d  = StData;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q != 3'd7) begin
            idx_d    = idx_inc;
            serial_d = byte_q[idx_inc];
          end else begin
            serial_d = 1'b1;
            state_d  = StStop;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StStop: begin
        if (bit_end) begin
          cnt_d    = '0;
          serial_d = 1'b1;
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
        state_d  = StIdle;
      end
    endcase
  end

  // Reset abandons any frame in progress and forces the line to mark immediately.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_TX_Serial = serial_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: a frame-position model checked every cycle on two instances
// (CLKS_PER_BIT 4 and 416), plus directed checks with hand-computed expectations.
module tb_uart_tx_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       dv4 = 1'b0, dv416 = 1'b0;
  logic [7:0] b4 = 8'h00, b416 = 8'h00;
  logic       a4, s4, d4, a416, s416, d416;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_core #(.CLKS_PER_BIT(4)) dut4 (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_TX_DV    (dv4),
    .i_TX_Byte  (b4),
    .o_TX_Active(a4),
    .o_TX_Serial(s4),
    .o_TX_Done  (d4)
  );

  uart_tx_core dut416 (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_TX_DV    (dv416),
    .i_TX_Byte  (b416),
    .o_TX_Active(a416),
    .o_TX_Serial(s416),
    .o_TX_Done  (d416)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just a start time and a byte; outputs follow from the
  // position t inside the frame. Returns {active, serial, done}.
  longint     cyc = 0;
  longint     st4 = -1, st416 = -1;
  logic [7:0] mb4 = 8'h00, mb416 = 8'h00;

  function automatic logic [2:0] expect_out(input longint st, input longint c, input int cpb,
                                            input logic [7:0] b);
    longint t;
    int     k;
    if (st < 0) return 3'b010;
    t = c - st;
    if (t < 10 * cpb) begin
      k = int'(t / cpb);
      if (k == 0) return 3'b100;
      if (k <= 8) return {1'b1, b[k-1], 1'b0};
      return 3'b110;
    end
    if (t == 10 * cpb) return 3'b011;
    return 3'b010;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st4   <= -1;
      st416 <= -1;
    end else begin
      if (dv4 && (st4 < 0 || cyc - st4 >= 40)) begin
        st4 <= cyc + 1;
        mb4 <= b4;
      end
      if (dv416 && (st416 < 0 || cyc - st416 >= 4160)) begin
        st416 <= cyc + 1;
        mb416 <= b416;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_cpb4", {29'd0, a4, s4, d4}, {29'd0, expect_out(st4, cyc, 4, mb4)});
    chk("model_cpb416", {29'd0, a416, s416, d416}, {29'd0, expect_out(st416, cyc, 416, mb416)});
  end

  task automatic pulse4(input logic [7:0] v);
    @(negedge clk);
    dv4 = 1'b1;
    b4  = v;
    @(negedge clk);
    dv4 = 1'b0;
  endtask

  // Mid-bit receiver for the CLKS_PER_BIT=4 line.
  task automatic rx4(output logic [7:0] v, output bit ok);
    ok = 1'b0;
    v  = 8'h00;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (s4 === 1'b0) ok = 1'b1;
    end
    if (ok) begin
      repeat (2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        v[k] = s4;
      end
      repeat (4) @(negedge clk);
      if (s4 !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int         a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int         lit_edges [4] = '{0, 1248, 2080, 3744};
  logic [7:0] msg [2] = '{8'h48, 8'h49};

  initial begin
    int         act_n, done_n, low_n, done_t;
    logic       prev;
    logic [7:0] rv;
    bit         ok;
    longint     edges [$];

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_cpb4", {29'd0, a4, s4, d4}, 32'h2);
    chk("reset_cpb416", {29'd0, a416, s416, d416}, 32'h2);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_line_high", {31'd0, s4}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_idle", {29'd0, a4, s4, d4}, 32'h2);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single byte 0xA5 at 4 clocks per bit
    pulse4(8'hA5);
    act_n  = 0;
    done_n = 0;
    for (int t = 0; t < 44; t++) begin
      if (t % 4 == 2 && t < 40) chk($sformatf("a5_bit%0d", t / 4), {31'd0, s4}, a5_seq[t/4]);
      if (t == 40) chk("a5_done_at_40", {31'd0, d4}, 32'd1);
      act_n  += int'(a4);
      done_n += int'(d4);
      @(negedge clk);
    end
    chk("a5_active_cycles", act_n, 40);
    chk("a5_done_cycles", done_n, 1);

    // Default divider, byte 0x0C
    @(negedge clk);
    dv416 = 1'b1;
    b416  = 8'h0C;
    @(negedge clk);
    dv416  = 1'b0;
    prev   = 1'b1;
    act_n  = 0;
    done_t = -1;
    for (int t = 0; t < 4170; t++) begin
      if (s416 !== prev) edges.push_back(t);
      prev   = s416;
      act_n += int'(a416);
      if (d416 === 1'b1) done_t = t;
      if (t == 415) chk("c416_start_last", {31'd0, s416}, 32'd0);
      @(negedge clk);
    end
    chk("c416_active_cycles", act_n, 4160);
    chk("c416_done_time", done_t, 4160);
    chk("c416_edge_count", edges.size(), 4);
    for (int i = 0; i < 4 && i < edges.size(); i++)
      chk($sformatf("c416_edge%0d", i), 32'(edges[i]), lit_edges[i]);

    // Back-to-back "HI", producer strobes whenever idle
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          ok = 1'b0;
          for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (a4 === 1'b0) ok = 1'b1;
          end
          chk($sformatf("b2b_idle_wait%0d", k), {31'd0, ok}, 32'd1);
          if (k == 1) chk("b2b_gap_idle_high", {30'd0, s4, d4}, 32'h3);
          dv4 = 1'b1;
          b4  = msg[k];
          @(negedge clk);
          dv4 = 1'b0;
        end
      end
      begin
        logic [7:0] r;
        bit         rok;
        for (int k = 0; k < 2; k++) begin
          rx4(r, rok);
          chk($sformatf("b2b_frame%0d_ok", k), {31'd0, rok}, 32'd1);
          chk($sformatf("b2b_byte%0d", k), {24'd0, r}, {24'd0, msg[k]});
        end
      end
    join
    repeat (12) @(negedge clk);

    // Busy strobe and input change mid-frame
    fork
      begin
        pulse4(8'h00);
        repeat (15) @(negedge clk);
        dv4 = 1'b1;
        b4  = 8'hFF;
        @(negedge clk);
        dv4 = 1'b0;
      end
      begin
        rx4(rv, ok);
        chk("busy_frame_ok", {31'd0, ok}, 32'd1);
        chk("busy_byte", {24'd0, rv}, 32'h00);
      end
    join
    done_n = 0;
    low_n  = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      done_n += int'(d4);
      low_n  += int'(!s4);
    end
    chk("busy_done_pulses", done_n, 1);
    chk("busy_no_ff_frame", low_n, 0);

    // Reset during data bit 3 of 0x55
    pulse4(8'h55);
    repeat (17) @(negedge clk);
    chk("pre_reset_bit3_low", {31'd0, s4}, 32'd0);
    #3 rst_n = 1'b0;
    #1 chk("midframe_reset_immediate", {29'd0, a4, s4, d4}, 32'h2);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    done_n = 0;
    low_n  = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      done_n += int'(d4);
      low_n  += int'(!s4);
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_line_high", low_n, 0);
    fork
      pulse4(8'h3C);
      begin
        rx4(rv, ok);
        chk("after_reset_frame_ok", {31'd0, ok}, 32'd1);
        chk("after_reset_byte", {24'd0, rv}, 32'h3C);
      end
    join
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
